// File: rtl/reg_bank_arbiter.sv
// Two-requester round-robin arbiter in front of a 4 x 8-bit register bank.
// Each access runs IDLE -> SERVE -> DONE: it is granted in SERVE, the bank is
// read or written at the edge that closes SERVE, and it is acknowledged in DONE.
//
// Ports:
//   Clk          system clock, rising edge
//   Reset        synchronous active-high reset
//   Req[1:0]     per-requester access request
//   We[1:0]      per-requester write enable (1 = write, 0 = read)
//   Addr0/Addr1  register index for requester 0 / 1
//   Din0/Din1    write data for requester 0 / 1
//   Gnt[1:0]     one-hot grant, high during SERVE
//   Ack[1:0]     one-cycle completion pulse, high during DONE
//   Dout[7:0]    result of the last completed access
//   Busy         high whenever the FSM is not in IDLE
module reg_bank_arbiter (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] Req,
  input  logic [1:0] We,
  input  logic [1:0] Addr0,
  input  logic [1:0] Addr1,
  input  logic [7:0] Din0,
  input  logic [7:0] Din1,
  output logic [1:0] Gnt,
  output logic [1:0] Ack,
  output logic [7:0] Dout,
  output logic       Busy
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned N_REQ  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                sel_q, sel_d;      // requester currently being served
  logic                last_q, last_d;    // requester served most recently
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   bank_q [DEPTH];
  logic [DATA_W-1:0]   bank_d [DEPTH];

  logic [ADDR_W-1:0]   addr_sel;
  logic [DATA_W-1:0]   din_sel;
  logic                we_sel;

  // Operand mux: the selected requester's address, data and write enable.
  always_comb begin
    addr_sel = sel_q ? Addr1 : Addr0;
    din_sel  = sel_q ? Din1  : Din0;
    we_sel   = sel_q ? We[1] : We[0];
  end

  // Next-state, arbitration and bank access.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    gnt_d   = '0;
    ack_d   = '0;
    dout_d  = dout_q;
    bank_d  = bank_q;

    case (state_q)
      IDLE: begin
        if (|Req) begin
          // On a tie the requester not served last wins; otherwise the lone one.
          if (Req == 2'b11) begin
            sel_d = ~last_q;
          end else begin
            sel_d = Req[1];
          end
          gnt_d   = sel_d ? 2'b10 : 2'b01;
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (we_sel) begin
          bank_d[addr_sel] = din_sel;
          dout_d           = din_sel;
        end else begin
          dout_d = bank_q[addr_sel];
        end
        ack_d   = sel_q ? 2'b10 : 2'b01;
        last_d  = sel_q;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset overrides any in-flight access.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      gnt_q   <= '0;
      ack_q   <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      bank_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      bank_q  <= bank_d;
    end
  end

  assign Gnt  = gnt_q;
  assign Ack  = ack_q;
  assign Dout = dout_q;
  assign Busy = busy_q;

endmodule

// File: doc/reg_bank_arbiter.md
REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 Clk  input  1  single system clock; all state updates on rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset; sampled on rising Clk edge.
REQ-003 Req  input  2  per-requester access request; bit i belongs to requester i.
REQ-004 We  input  2  per-requester write enable; 1 = write, 0 = read; qualified by Req[i].
REQ-005 Addr0, Addr1  input  2 each  register index (0-3) for requester 0 and requester 1.
REQ-006 Din0, Din1  input  8 each  write data for requester 0 and requester 1.
REQ-007 Gnt  output  2  one-hot grant; bit i high while requester i is being served.
REQ-008 Ack  output  2  one-cycle completion pulse to the served requester.
REQ-009 Dout  output  8  registered result of the last completed access.
REQ-010 Busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 Block SHALL contain a 4-entry x 8-bit register bank of edge-triggered storage, accessible only through this arbiter.
REQ-012 FSM SHALL have three states: IDLE, SERVE, DONE.
REQ-013 IDLE: if any Req bit is high, SHALL select one requester, latch its id, and go to SERVE next cycle; else SHALL stay in IDLE.
REQ-014 Selection SHALL be round-robin: a lone requester always wins; on simultaneous Req=2'b11, the requester not served last SHALL win.
REQ-015 Last-served pointer SHALL update only on entry to DONE.
REQ-016 SERVE lasts exactly one cycle: Gnt[sel]=1, other Gnt bit 0.
REQ-017 SERVE with We[sel]=1: at the closing edge, bank[Addr_sel] <= Din_sel and Dout <= Din_sel.
REQ-018 SERVE with We[sel]=0: at the closing edge, Dout <= bank[Addr_sel]; bank SHALL be unchanged.
REQ-019 Addr, Din and We SHALL be sampled from the selected requester during SERVE; the requester holds them stable from Req assertion until Ack.
REQ-020 DONE lasts exactly one cycle: Ack[sel]=1, Gnt=2'b00; next state SHALL be IDLE unconditionally.
REQ-021 Latency: Req sampled high at edge k gives Gnt high in cycle k+1, Ack high in cycle k+2 and IDLE in cycle k+3; throughput is at most one access per 3 cycles.
REQ-022 If Req[sel] is still high in IDLE after its Ack, it SHALL count as a new request.
REQ-023 A Req bit deasserted during SERVE SHALL NOT abort the access; it completes and is acknowledged.
REQ-024 The non-selected requester SHALL see Gnt and Ack low and SHALL wait; no request is dropped.
REQ-025 Outputs SHALL be glitch-free registered or state-decoded signals; Gnt and Ack SHALL never both be nonzero in the same cycle.

Reset
REQ-026 On Reset=1 at a rising edge, SHALL set: state=IDLE, Gnt=2'b00, Ack=2'b00, Busy=0, Dout=8'h00, all bank entries=8'h00, last-served pointer=1 (requester 0 wins the first tie).
REQ-027 Reset SHALL take priority over every other input.
REQ-028 Reset asserted in SERVE SHALL suppress the write and the Ack; no bank entry changes except the clear to 0.
REQ-029 After Reset deasserts, Req SHALL be evaluated in the first IDLE cycle.

Verification
REQ-030 Reset, then Req=01, We=01, Addr0=2, Din0=8'hA5 -> Gnt=01 in cycle 1, Ack=01 in cycle 2, Dout=8'hA5, bank[2]=8'hA5.
REQ-031 After REQ-030, Req=10, We=00, Addr1=2 -> Gnt=10, then Ack=10, Dout=8'hA5.
REQ-032 Reset, then Req=11 held, both writes (Addr0=0/Din0=8'h11, Addr1=1/Din1=8'h22) -> grant order 01,10,01,10; Acks alternate; each access takes 3 cycles.
REQ-033 Reset asserted during SERVE of a write of 8'hFF to Addr0=3 -> no Ack; bank[3]=8'h00; Busy=0 next cycle.
REQ-034 Read of each address immediately after reset -> Dout=8'h00 for all four entries.
REQ-035 Req0 pulsed high for one IDLE cycle only -> full access completes; Ack=01 is issued exactly once.
